// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares the single-port data RAM between two requesters: port 0 (CPU
// load/store unit) and port 1 (program loader / debug DMA). Each port uses a
// req/gnt/rvalid handshake for word accesses. Ties are broken round-robin.
// All RAM-side outputs come from registered state and the latched payload, so
// there is no combinational path from a requester to the RAM. The RAM's
// one-cycle-latency read data is steered back to the port that won.
//
// Ports:
//   clk               single clock, shared with the RAM
//   rstn              asynchronous active-low reset
//   req0/req1         access request, held with payload until gnt
//   we0/we1           1 = write, 0 = read
//   addr0/addr1       byte address, forwarded unmodified
//   wdata0/wdata1     write data
//   gnt0/gnt1         one-cycle pulse: payload has been latched
//   rvalid0/rvalid1   one-cycle pulse: read data valid (reads only)
//   rdata0/rdata1     ram_rdata while the matching rvalid is high, else 0
//   ram_we            to ram.we
//   ram_addr          to ram.addr
//   ram_wdata         to ram.data_write
//   ram_rdata         from ram.data_read (one-cycle latency)
//   busy              arbiter is in ISSUE or RESP
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         ram_we,
    output logic [N-1:0] ram_addr,
    output logic [N-1:0] ram_wdata,
    input  logic [N-1:0] ram_rdata,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;

    // Latched payload of the access currently being served.
    logic         r_win;      // winning port id
    logic         r_we;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic         r_last;     // port that won most recently

    logic         w_take;     // a new access is accepted this cycle
    logic         w_win;      // port that wins this cycle's arbitration

    // -----------------------------------------------------------------------
    // Arbitration and next state
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_take = 1'b0;
        w_win  = 1'b0;
        w_next = IDLE;

        // On a tie the port that did not win last time goes next;
        // otherwise whichever port is requesting wins.
        if (req0 && req1) begin
            w_win = ~r_last;
        end else begin
            w_win = req1;
        end

        case (r_state)
            IDLE, RESP: begin
                // RESP arbitrates too, which keeps back-to-back accesses at
                // one per two cycles.
                w_take = req0 | req1;
                w_next = w_take ? ISSUE : IDLE;
            end
            ISSUE: begin
                w_next = RESP;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and payload registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= 1'b1;   // port 0 wins the first tie after reset
        end else if (w_take) begin
            r_win   <= w_win;
            r_we    <= w_win ? we1    : we0;
            r_addr  <= w_win ? addr1  : addr0;
            r_wdata <= w_win ? wdata1 : wdata0;
            r_last  <= w_win;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode: only registered state and latched payload feed the RAM
    // side. Because the state resets asynchronously, ram_we, gnt and rvalid
    // drop the moment rstn is asserted, aborting a write still in ISSUE.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        ram_we    = 1'b0;
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        busy      = (r_state != IDLE);

        case (r_state)
            ISSUE: begin
                ram_we = r_we;
                gnt0   = ~r_win;
                gnt1   = r_win;
            end
            RESP: begin
                // The RAM returns the word addressed in ISSUE during this
                // cycle; writes produce no response.
                if (!r_we) begin
                    rvalid0 = ~r_win;
                    rvalid1 = r_win;
                    if (r_win) begin
                        rdata1 = ram_rdata;
                    end else begin
                        rdata0 = ram_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule
